// File: rtl/instr_sequencer.sv
// Program sequencer: fetches ROM words, decodes opcode/immediate and drives the ALU; handles JMP/JC/NOP/HALT.
// 3 cycles per instruction (FETCH, DECODE, EXEC); start is honoured only in IDLE or HALT.
module instr_sequencer #(
    parameter int data_width    = 8,
    parameter int op_code_width = 4,
    parameter int addr_width    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [addr_width-1:0]               pc_addr,
    input  logic [op_code_width+data_width-1:0] instr_in,
    input  logic                                cy,
    output logic [op_code_width-1:0]            opcode,
    output logic                                acc_ce,
    output logic [data_width-1:0]               data_out,
    output logic                                busy,
    output logic                                halted
);

    localparam int IW = op_code_width + data_width;
    localparam logic [op_code_width-1:0] OP_JMP = op_code_width'(12);
    localparam logic [op_code_width-1:0] OP_JC  = op_code_width'(13);
    localparam logic [op_code_width-1:0] OP_NOP = op_code_width'(14);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [addr_width-1:0]     r_pc;
    logic [addr_width-1:0]     w_pc_nxt;
    logic [addr_width-1:0]     w_pc_inc;
    logic [addr_width-1:0]     w_imm_addr;
    logic [IW-1:0]             r_ir;
    logic [IW-1:0]             w_ir_nxt;
    logic [op_code_width-1:0]  w_op;
    logic [data_width-1:0]     w_imm;
    logic                      r_armed;
    logic                      w_start;
    logic                      w_acc_ce;

    assign w_op     = r_ir[IW-1 -: op_code_width];
    assign w_imm    = r_ir[data_width-1:0];
    assign w_pc_inc = r_pc + 1'b1;

    generate
        if (data_width >= addr_width) begin : g_imm_trunc
            assign w_imm_addr = w_imm[addr_width-1:0];
        end else begin : g_imm_zext
            assign w_imm_addr = {{(addr_width - data_width){1'b0}}, w_imm};
        end
    endgenerate

    // r_armed stays low for the first edge after reset release, so a start
    // pulse coinciding with reset deassertion is dropped.
    assign w_start = start & r_armed;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_acc_ce    = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (w_start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_ir_nxt    = instr_in;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                if (w_op < OP_JMP) begin
                    w_acc_ce = 1'b1;
                    w_pc_nxt = w_pc_inc;
                end else if (w_op == OP_JMP) begin
                    w_pc_nxt = w_imm_addr;
                end else if (w_op == OP_JC) begin
                    w_pc_nxt = cy ? w_imm_addr : w_pc_inc;
                end else if (w_op == OP_NOP) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_armed <= 1'b1;
        end
    end

    // Every output is decoded from registers only, so reset clears them immediately.
    assign pc_addr  = r_pc;
    assign opcode   = w_op;
    assign data_out = w_imm;
    assign acc_ce   = w_acc_ce;
    assign busy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: synchronous ROM model, table-driven per-cycle vectors, hand-written reset corners.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cy = 1'b0;
    logic [7:0]  pc_addr;
    logic [11:0] instr_in;
    logic [3:0]  opcode;
    logic        acc_ce;
    logic [7:0]  data_out;
    logic        busy;
    logic        halted;

    logic [11:0] rom [256];
    logic [11:0] rom_q = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       s;
        logic       c;
        logic [7:0] pc;
        logic       a;
        logic [3:0] op;
        logic [7:0] d;
        logic       b;
        logic       h;
    } vec_t;

    vec_t tbl[$];

    instr_sequencer #(.data_width(8), .op_code_width(4), .addr_width(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_addr(pc_addr), .instr_in(instr_in),
        .cy(cy), .opcode(opcode), .acc_ce(acc_ce), .data_out(data_out),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_q <= rom[pc_addr];
    assign instr_in = rom_q;

    function automatic vec_t mk(logic s, logic c, logic [7:0] pc, logic a, logic [3:0] op,
                                logic [7:0] d, logic b, logic h);
        vec_t v;
        v.s = s; v.c = c; v.pc = pc; v.a = a; v.op = op; v.d = d; v.b = b; v.h = h;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, pc_addr, acc_ce, opcode, data_out, busy, halted};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        cy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    // Entered 1 time unit after a rising edge; row i is applied and checked in cycle i.
    task automatic run_table(string name);
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].s;
            cy    = tbl[i].c;
            @(negedge clk);
            chk($sformatf("%s[%0d]", name, i), outs(),
                {9'd0, tbl[i].pc, tbl[i].a, tbl[i].op, tbl[i].d, tbl[i].b, tbl[i].h});
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic load_straight();
        rom_clear();
        rom[0] = 12'h105;
        rom[1] = 12'h203;
        rom[2] = 12'hF00;
        tbl = {};
        tbl.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0)); // IDLE, start
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 4'h1, 8'h05, 1, 0)); // EXEC add 5
        tbl.push_back(mk(0, 0, 8'h01, 0, 4'h1, 8'h05, 1, 0));
        tbl.push_back(mk(1, 0, 8'h01, 0, 4'h1, 8'h05, 1, 0)); // start in DECODE ignored
        tbl.push_back(mk(0, 0, 8'h01, 1, 4'h2, 8'h03, 1, 0)); // EXEC op 2
        tbl.push_back(mk(0, 0, 8'h02, 0, 4'h2, 8'h03, 1, 0));
        tbl.push_back(mk(0, 0, 8'h02, 0, 4'h2, 8'h03, 1, 0));
        tbl.push_back(mk(0, 0, 8'h02, 0, 4'hF, 8'h00, 1, 0)); // EXEC halt
        tbl.push_back(mk(0, 0, 8'h02, 0, 4'hF, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 8'h02, 0, 4'hF, 8'h00, 0, 1)); // start in HALT
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hF, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hF, 8'h00, 1, 0));
    endtask

    initial begin
        rom_clear();

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle[%0d]", i), outs(), 32'd0);
        end
        @(posedge clk);
        #1;

        // Straight-line program, start in DECODE and in HALT
        do_reset();
        load_straight();
        run_table("straight");

        // JMP to 255, NOP wraps to 0, refetch
        do_reset();
        rom_clear();
        rom[0]   = 12'hCFF;
        rom[255] = 12'hE00;
        tbl = {};
        tbl.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hC, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 4'hC, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 4'hC, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 4'hE, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hE, 8'h00, 1, 0)); // wrapped
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hE, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hC, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 4'hC, 8'hFF, 1, 0));
        run_table("jmp_wrap");

        // JC taken: cy high only in EXEC
        do_reset();
        rom_clear();
        rom[0] = 12'hD10;
        tbl = {};
        tbl.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 4'hD, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 8'h10, 0, 4'hD, 8'h10, 1, 0));
        run_table("jc_taken");

        // JC not taken: cy low only in EXEC
        do_reset();
        tbl = {};
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'hD, 8'h10, 1, 0));
        tbl.push_back(mk(0, 1, 8'h01, 0, 4'hD, 8'h10, 1, 0));
        run_table("jc_not_taken");

        // Asynchronous reset in the middle of an ALU EXEC
        do_reset();
        load_straight();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_acc_ce", {31'd0, acc_ce}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_outs", outs(), 32'd0);
        do_reset();
        run_table("restart");

        // start held through reset release is not taken
        rst = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_at_rst_release", outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
